// File: rtl/hann_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hann_pkg : shared constants, stage record and half-table of the 32-point  |
// |            Hann window (unsigned Q1.11 coefficients).                     |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
package hann_pkg;

    localparam int HANN_N     = 32;
    localparam int HANN_DW    = 12;
    localparam int HANN_CW    = 13;
    localparam int HANN_AW    = 5;
    localparam int HANN_ONE   = 2048;
    localparam int HANN_SHIFT = 11;
    localparam int HANN_RND   = 1024;

    // Indices 0..16; entries 17..31 are the mirror image of 15..1.
    localparam logic [HANN_CW-1:0] HANN_HALF_TABLE [0:16] = '{
        13'd0,    13'd20,   13'd78,   13'd173,  13'd300,  13'd455,
        13'd632,  13'd824,  13'd1024, 13'd1224, 13'd1416, 13'd1593,
        13'd1748, 13'd1875, 13'd1970, 13'd2028, 13'd2047
    };

    typedef struct packed {
        logic               valid;
        logic [HANN_AW-1:0] idx;
        logic [HANN_DW-1:0] data;
    } hann_stage_t;

    function automatic logic [HANN_AW-1:0] hann_fold(input logic [HANN_AW-1:0] k);
        return (k > 5'd16) ? 5'(6'd32 - {1'b0, k}) : k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hann_coef_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hann_coef_rom : synchronous Hann coefficient ROM, 1-cycle read latency,   |
// |                 folds the 32-entry address onto the 17-entry half-table.  |
// | Revision      : 1.0                                                       |
// +----------------------------------------------------------------------------+
module hann_coef_rom
    import hann_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [HANN_AW-1:0] addr,
    output logic [HANN_CW-1:0] data
);

    logic [HANN_CW-1:0] data_d;
    logic [HANN_CW-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = HANN_HALF_TABLE[hann_fold(addr)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule
`default_nettype wire

// File: rtl/hann_window_apply.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hann_window_apply : 3-stage Hann windowing of a signed sample stream with |
// |                     frame tracking. Build option HANN_BYPASS_EN adds a    |
// |                     per-sample unity-gain bypass input.                   |
// | Revision          : 1.0                                                   |
// +----------------------------------------------------------------------------+
module hann_window_apply
    import hann_pkg::*;
#(
    parameter int N  = HANN_N,
    parameter int DW = HANN_DW,
    parameter int CW = HANN_CW
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef HANN_BYPASS_EN
    input  logic                 bypass,
`endif
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_sof,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_data,
    output logic                 m_first,
    output logic                 m_last,
    output logic                 frame_err
);

    localparam int PW = DW + CW;
    localparam logic [HANN_AW-1:0] LAST_IDX = HANN_AW'(N - 1);

    logic                en;
    logic                accept;
    logic [HANN_AW-1:0]  use_idx;
    logic [HANN_AW-1:0]  idx_d,  idx_q;
    hann_stage_t         s1_d,   s1_q;
    hann_stage_t         s2_d,   s2_q;
    logic [CW-1:0]       rom_coef;
    logic [CW-1:0]       coef_eff;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] rnd_sum;
    logic                m_valid_d, m_valid_q;
    logic [DW-1:0]       m_data_d,  m_data_q;
    logic                m_first_d, m_first_q;
    logic                m_last_d,  m_last_q;

    assign en      = !m_valid_q || m_ready;
    assign s_ready = en;
    assign accept  = s_valid && en;

    // Frame counter: s_sof forces the accepted sample to index 0.
    always_comb begin
        idx_d     = idx_q;
        use_idx   = s_sof ? '0 : idx_q;
        frame_err = accept && s_sof && (idx_q != '0);
        if (accept) begin
            idx_d = (use_idx == LAST_IDX) ? '0 : use_idx + 5'd1;
        end
    end

    hann_coef_rom u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .addr  (s1_q.idx),
        .data  (rom_coef)
    );

`ifdef HANN_BYPASS_EN
    logic s1_byp_d, s1_byp_q;
    logic s2_byp_d, s2_byp_q;

    always_comb begin
        s1_byp_d = s1_byp_q;
        s2_byp_d = s2_byp_q;
        if (en) begin
            s1_byp_d = bypass;
            s2_byp_d = s1_byp_q;
        end
        coef_eff = s2_byp_q ? CW'(HANN_ONE) : rom_coef;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_byp_q <= 1'b0;
            s2_byp_q <= 1'b0;
        end else begin
            s1_byp_q <= s1_byp_d;
            s2_byp_q <= s2_byp_d;
        end
    end
`else
    assign coef_eff = rom_coef;
`endif

    // Coefficient is unsigned, so it is zero-extended before the signed multiply.
    assign prod    = $signed({{(PW-DW){s2_q.data[DW-1]}}, s2_q.data})
                   * $signed({{(PW-CW){1'b0}}, coef_eff});
    assign rnd_sum = prod + $signed(PW'(HANN_RND));

    always_comb begin
        s1_d      = s1_q;
        s2_d      = s2_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_first_d = m_first_q;
        m_last_d  = m_last_q;
        if (en) begin
            s1_d.valid = accept;
            s1_d.idx   = use_idx;
            s1_d.data  = s_data;
            s2_d       = s1_q;
            m_valid_d  = s2_q.valid;
            m_first_d  = s2_q.valid && (s2_q.idx == '0);
            m_last_d   = s2_q.valid && (s2_q.idx == LAST_IDX);
            if (s2_q.valid) begin
                m_data_d = DW'(rnd_sum >>> HANN_SHIFT);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_first_q <= m_first_d;
            m_last_q  <= m_last_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_first = m_first_q;
    assign m_last  = m_last_q;

endmodule
`default_nettype wire

// File: tb/tb_hann_window_apply.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hann_window_apply : directed, table-driven bench for hann_window_apply.|
// | Revision             : 1.0                                                |
// +----------------------------------------------------------------------------+
module tb_hann_window_apply;

    logic               clk     = 1'b0;
    logic               rst_n   = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_sof   = 1'b0;
    logic               m_ready = 1'b1;
    logic               bypass  = 1'b0;
    logic signed [11:0] s_data  = '0;
    logic               s_ready;
    logic               m_valid;
    logic               m_first;
    logic               m_last;
    logic               frame_err;
    logic signed [11:0] m_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    hann_window_apply dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef HANN_BYPASS_EN
        .bypass    (bypass),
`endif
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_first   (m_first),
        .m_last    (m_last),
        .frame_err (frame_err)
    );

    typedef struct {
        logic signed [11:0] data;
        logic               first;
        logic               last;
        int                 acc_cycle;
        bit                 chk_lat;
    } exp_t;

    typedef struct {
        logic signed [11:0] din;
        logic               sof;
        logic signed [11:0] dout;
        logic               first;
        logic               last;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl [96];

    // Hand-computed window of a constant 1000 input, indices 0..16.
    int win1000 [17] = '{0, 10, 38, 84, 146, 222, 309, 402, 500,
                         598, 691, 778, 854, 916, 962, 990, 1000};

    function automatic int w1000(input int k);
        return (k <= 16) ? win1000[k] : win1000[32 - k];
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: every transferred output is matched against the next expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("m_data",  m_data,  e.data);
                check("m_first", m_first, e.first);
                check("m_last",  m_last,  e.last);
                if (e.chk_lat) check("latency", cycle - e.acc_cycle, 3);
            end
        end
    end

    task automatic send(input logic signed [11:0] d, input logic sof, input logic byp,
                        input logic signed [11:0] ed, input logic ef, input logic el,
                        input logic eerr, input bit lat);
        int waited;
        waited  = 0;
        s_data  = d;
        s_sof   = sof;
        bypass  = byp;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) begin
            check("accept_timeout", 0, 1);
        end else begin
            check("frame_err", frame_err, eerr);
            exp_q.push_back('{ed, ef, el, cycle, lat});
        end
        @(posedge clk);
        #2;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        bypass  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic signed [11:0] held;
        logic signed [11:0] r;

        // Three full frames: constant 1000, then extreme/negative cases.
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 32; k++) begin
                tbl[f*32+k] = '{12'sd0, (k == 0), 12'sd0, (k == 0), (k == 31)};
                if (f == 0) begin
                    tbl[f*32+k].din  = 12'sd1000;
                    tbl[f*32+k].dout = 12'(w1000(k));
                end
            end
        end
        tbl[32+1].din  = -12'sd100;  tbl[32+1].dout  = -12'sd1;
        tbl[32+8].din  = 12'sd2047;  tbl[32+8].dout  = 12'sd1024;
        tbl[32+16].din = -12'sd2048; tbl[32+16].dout = -12'sd2047;
        tbl[64+4].din  = -12'sd1000; tbl[64+4].dout  = -12'sd146;
        tbl[64+16].din = 12'sd2047;  tbl[64+16].dout = 12'sd2046;
        tbl[64+31].din = 12'sd2047;  tbl[64+31].dout = 12'sd20;

        // Reset state
        #3;
        check("rst_m_valid",   m_valid,   0);
        check("rst_m_data",    m_data,    0);
        check("rst_m_first",   m_first,   0);
        check("rst_m_last",    m_last,    0);
        check("rst_frame_err", frame_err, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_reset", s_ready, 1);
        @(posedge clk);
        #2;

        // Table-driven frames, streamed back to back
        for (int i = 0; i < 96; i++) begin
            send(tbl[i].din, tbl[i].sof, 1'b0, tbl[i].dout, tbl[i].first, tbl[i].last,
                 1'b0, (i == 0));
        end
        drain();

        // Back-pressure for 5 cycles mid-frame
        fork
            begin
                for (int k = 0; k < 32; k++)
                    send(12'sd1000, (k == 0), 1'b0, 12'(w1000(k)), (k == 0), (k == 31), 1'b0, 1'b0);
            end
            begin
                repeat (12) @(posedge clk);
                #2;
                m_ready = 1'b0;
                @(negedge clk);
                held = m_data;
                check("stall_m_valid", m_valid, 1);
                check("stall_s_ready", s_ready, 0);
                repeat (4) begin
                    @(negedge clk);
                    check("stall_hold_data", m_data, held);
                    check("stall_s_ready", s_ready, 0);
                end
                @(posedge clk);
                #2;
                m_ready = 1'b1;
            end
        join
        drain();

        // Resync: s_sof on the 10th sample of a frame
        for (int k = 0; k < 9; k++)
            send(12'sd1000, (k == 0), 1'b0, 12'(w1000(k)), (k == 0), 1'b0, 1'b0, 1'b0);
        send(12'sd1000, 1'b1, 1'b0, 12'sd0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k < 32; k++)
            send(12'sd1000, 1'b0, 1'b0, 12'(w1000(k)), 1'b0, (k == 31), 1'b0, 1'b0);
        drain();

        // Asynchronous reset with three samples in flight
        for (int k = 0; k < 8; k++)
            send(12'sd1000, (k == 0), 1'b0, 12'(w1000(k)), (k == 0), 1'b0, 1'b0, 1'b0);
        #2;
        check("pre_reset_m_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_m_valid", m_valid, 0);
        check("async_reset_m_data",  m_data,  0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("no_stale_output", m_valid, 0);
        end
        @(posedge clk);
        #2;
        for (int k = 0; k < 32; k++)
            send(12'sd1000, 1'b0, 1'b0, 12'(w1000(k)), (k == 0), (k == 31), 1'b0, 1'b0);
        drain();

`ifdef HANN_BYPASS_EN
        // Unity-gain bypass on random samples
        for (int k = 0; k < 32; k++) begin
            r = 12'($urandom);
            send(r, (k == 0), 1'b1, r, (k == 0), (k == 31), 1'b0, (k == 0));
        end
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hann_window_apply.md
Name: hann_window_apply

Overview:
- Windowing stage that consumes the 32-point Hann coefficient sequence and applies it to a stream of signed 12-bit ADC samples.
- Sits between the sample acquisition path and the 32-point FFT/spectrum stage.
- Each accepted sample is multiplied by the coefficient for its position in the frame, rounded back to 12 bits, and emitted with frame markers.
- Frame position is tracked internally; the coefficient table is indexed by that position, not free-running from reset.

Parameters:
- N, 32, frame length in samples; the table is defined only for 32.
- DW, 12, sample width in bits (signed two's complement).
- CW, 13, coefficient width in bits (unsigned Q1.11; 2048 = 1.0).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  stage can accept (combinational).
- s_data  in  DW  signed input sample.
- s_sof  in  1  marks this sample as frame index 0 (resync).
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DW  signed windowed sample.
- m_first  out  1  output is frame index 0.
- m_last  out  1  output is frame index 31.
- frame_err  out  1  one-cycle pulse: s_sof arrived while index was not 0.

Behaviour:
- Reset (async, rst_n=0): all pipeline valids=0, m_data=0, m_first=0, m_last=0, frame_err=0, idx=0. s_ready=1 once out of reset.
- Handshake:
  - Global enable en = !m_valid || m_ready; s_ready = en.
  - A sample is accepted when s_valid && s_ready.
  - When en=0, all stages hold.
  - m_data, m_first and m_last are stable while m_valid && !m_ready.
- Pipeline, latency 3 accepted-enable cycles:
  - S1: register sample and index; present index to the coefficient ROM.
  - S2: ROM output valid; signed multiply, product 25 bits.
  - S3: round and register to the output.
- Frame counter idx (5 bits):
  - Increments on each accepted sample; wraps 31 -> 0.
  - Accepted sample with s_sof=1 uses index 0; idx becomes 1.
  - s_sof=1 with idx != 0 pulses frame_err in the accept cycle; the sample is still processed as index 0.
  - s_sof=1 with idx=0 is normal, with no error.
- Coefficient table: 13-bit unsigned values, index k and 32-k equal.
  - 0:0, 1:20, 2:78, 3:173, 4:300, 5:455, 6:632, 7:824, 8:1024, 9:1224, 10:1416, 11:1593, 12:1748, 13:1875, 14:1970, 15:2028, 16:2047.
  - 17..31 mirror 15..1.
- Arithmetic:
  - y = (x*c + 1024) >>> 11 (arithmetic shift, round half up).
  - |result| <= 2048 for all inputs, so no saturation logic is required.
  - Result is truncated to DW bits; the only 2048-magnitude case is -2048, which fits.
- m_first and m_last are derived from the index travelling with the sample, not from the live counter.
- Reset mid-frame discards in-flight samples; the next accepted sample is index 0.

Optional Feature:
- Macro HANN_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit), sampled with each accepted sample.
  - When bypass=1, the coefficient is forced to 2048, so m_data = s_data exactly.
  - Latency, handshake and frame markers are unchanged.
- When undefined: no bypass port; the coefficient always comes from the table.

Decomposition:
- Shared package hann_pkg holds:
  - Constants HANN_N=32, HANN_DW=12, HANN_CW=13, HANN_ONE=2048, HANN_SHIFT=11, HANN_RND=1024.
  - The 17-entry half-table constant.
- One sub-module, hann_coef_rom: synchronous ROM, 5-bit address, 13-bit data, 1-cycle latency, read enable = en.
  - Mirrors the address (k>16 -> 32-k) internally.

Test Plan:
- Reset, then 32 samples of s_data=1000 with s_sof on the first, m_ready=1 -> outputs 0,10,38,84,146,222,309,402,500,598,691,778,854,916,962,990,1000, then mirrored. m_first on output 0, m_last on output 31, first m_valid 3 cycles after the first accept.
- Extremes at index 16 -> s_data=-2048 gives -2047; s_data=2047 gives 2046. Index 8 with s_data=2047 gives 1024; index 1 with s_data=-100 gives -1.
- Back-pressure -> hold m_ready=0 for 5 cycles mid-frame. s_ready=0, m_data held, no samples lost or duplicated, frame order preserved.
- Resync -> s_sof asserted on the 10th sample of a frame. frame_err pulses once, that sample uses coefficient 0 (m_data=0, m_first=1), and the following sample uses 20.
- Async reset mid-frame with 3 samples in flight -> m_valid drops immediately, no stale outputs after release, next sample is index 0.
- HANN_BYPASS_EN build, bypass=1, 32 random samples -> m_data equals s_data after 3 cycles.
